// File: rtl/m_icache_direct_pkg.sv
// m_icache_direct_pkg: FSM encodings and geometry helpers shared by the I-cache files
package m_icache_direct_pkg;
  localparam logic [1:0] S_DRAIN = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_MISS = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;
  localparam int D_DELAY = 10;
  localparam int MEM_DELAY_DEF = D_DELAY;
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - 2 - $clog2(lines);
  endfunction
endpackage

// File: rtl/m_icache_array.sv
// m_icache_array: valid/tag/data storage, async read by index, sync write, single-cycle clear-all
module m_icache_array
  import m_icache_direct_pkg::*;
#(
  parameter int LINES = 16,
  parameter int TAG_W = 7,
  localparam int IDX_W = idx_w(LINES)
) (
  input  logic             w_clock,
  input  logic             w_rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic             clr
);
  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  logic [31:0] r_data [LINES];
  assign rd_valid = r_valid[rd_idx];
  assign rd_tag = r_tag[rd_idx];
  assign rd_data = r_data[rd_idx];
  // clear beats a coincident fill, so a line filled during fence.i ends invalid
  always_ff @(posedge w_clock)
    if (!w_rst_n || clr) r_valid <= '0;
    else if (wr_en) r_valid[wr_idx] <= 1'b1;
  always_ff @(posedge w_clock)
    if (wr_en) begin
      r_tag[wr_idx] <= wr_tag;
      r_data[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/m_icache_direct.sv
// m_icache_direct: direct-mapped one-word-line I-cache in front of the DRAM; ICACHE_STATS_EN adds r_hits/r_misses
module m_icache_direct
  import m_icache_direct_pkg::*;
#(
  parameter int LINES = 16,
  parameter int ADDR_W = 13,
  parameter int MEM_DELAY = MEM_DELAY_DEF
) (
  input  logic        w_clock,
  input  logic        w_rst_n,
  input  logic [31:0] w_pc,
  input  logic        w_re,
  output logic [31:0] r_insn,
  output logic        r_oe,
  output logic [31:0] w_mem_addr,
  output logic        w_mem_re,
  input  logic [31:0] w_mem_insn,
  input  logic        w_mem_oe,
  input  logic        w_inval
);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);
  localparam int CNT_W = $clog2(MEM_DELAY + 1);
  logic [1:0] r_state, state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_pc;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0] rd_data;
  logic rd_valid, hit, miss, fill, unused_pc;
  m_icache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .w_clock (w_clock),
    .w_rst_n (w_rst_n),
    .rd_idx  (w_pc[2+IDX_W-1:2]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (fill),
    .wr_idx  (r_pc[2+IDX_W-1:2]),
    .wr_tag  (r_pc[ADDR_W-1:2+IDX_W]),
    .wr_data (w_mem_insn),
    .clr     (w_inval)
  );
  assign hit = r_state == S_IDLE && w_re && rd_valid && rd_tag == w_pc[ADDR_W-1:2+IDX_W];
  assign miss = r_state == S_IDLE && w_re && !hit;
  assign fill = r_state == S_MISS && w_mem_oe;
  assign w_mem_re = r_state == S_MISS;
  assign w_mem_addr = r_pc;
  assign unused_pc = ^{w_pc[31:ADDR_W], w_pc[1:0]};
  // the drain lets any DRAM access begun before reset finish before new requests go out
  always_comb
    state_nxt = r_state == S_DRAIN ? (r_cnt == CNT_W'(MEM_DELAY - 1) ? S_IDLE : S_DRAIN)
              : hit || fill ? S_RESP
              : miss ? S_MISS
              : r_state == S_RESP ? S_IDLE : r_state;
  always_ff @(posedge w_clock)
    if (!w_rst_n) begin
      r_state <= S_DRAIN;
      r_cnt <= '0;
      r_pc <= '0;
      r_oe <= 1'b0;
      r_insn <= '0;
    end else begin
      r_state <= state_nxt;
      r_cnt <= r_state == S_DRAIN ? r_cnt + 1'b1 : r_cnt;
      r_pc <= hit || miss ? w_pc : r_pc;
      r_oe <= hit || fill;
      r_insn <= hit ? rd_data : fill ? w_mem_insn : '0;
    end
`ifdef ICACHE_STATS_EN
  logic [31:0] r_hits, r_misses;
  always_ff @(posedge w_clock)
    if (!w_rst_n) begin
      r_hits <= '0;
      r_misses <= '0;
    end else begin
      r_hits <= hit && ~&r_hits ? r_hits + 1'b1 : r_hits;
      r_misses <= miss && ~&r_misses ? r_misses + 1'b1 : r_misses;
    end
`endif
endmodule

// File: tb/tb_m_icache_direct.sv
// tb_m_icache_direct: scoreboarded random/directed fetches against a behavioural cache and DRAM model
module tb_m_icache_direct;
  localparam int LINES = 16;
  localparam int ADDR_W = 13;
  localparam int MEM_DELAY = 10;
  localparam int MISS_LAT = 11;
  typedef struct {
    logic [31:0] insn;
    int issue;
    int lat;
  } exp_t;
  logic w_clock = 0, w_rst_n = 0, w_re = 0, w_mem_oe = 0, inval_pulse = 0, inval_on_fill = 0;
  logic [31:0] w_pc = 0, w_mem_insn = 0;
  logic [31:0] r_insn, w_mem_addr;
  logic r_oe, w_mem_re, w_inval;
  logic [31:0] mem [2048];
  bit mv [LINES];
  int unsigned mt [LINES];
  logic [31:0] md [LINES];
  exp_t exp_q [$];
  int cyc = 0, checks = 0, failures = 0, d_cnt = 0;
  int unsigned d_addr = 0;
  bit started = 0, d_busy = 0;

  assign w_inval = inval_pulse | (inval_on_fill & w_mem_oe);
  always #5 w_clock = ~w_clock;

  m_icache_direct dut (
    .w_clock   (w_clock),
    .w_rst_n   (w_rst_n),
    .w_pc      (w_pc),
    .w_re      (w_re),
    .r_insn    (r_insn),
    .r_oe      (r_oe),
    .w_mem_addr(w_mem_addr),
    .w_mem_re  (w_mem_re),
    .w_mem_insn(w_mem_insn),
    .w_mem_oe  (w_mem_oe),
    .w_inval   (w_inval)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % LINES;
  endfunction
  function automatic int unsigned m_tag(input logic [31:0] pc);
    return (pc % (1 << ADDR_W)) / (4 * LINES);
  endfunction
  function automatic int unsigned m_word(input logic [31:0] pc);
    return (pc / 4) % 2048;
  endfunction

  // DRAM: accepts a request, answers MEM_DELAY cycles later even across a reset
  always @(negedge w_clock) begin
    if (d_busy) begin
      d_cnt++;
      if (d_cnt == MEM_DELAY) begin
        w_mem_oe = 1;
        w_mem_insn = mem[d_addr];
        d_busy = 0;
      end
    end else begin
      w_mem_oe = 0;
      w_mem_insn = 0;
      if (w_mem_re === 1'b1) begin
        d_busy = 1;
        d_cnt = 1;
        d_addr = m_word(w_mem_addr);
      end
    end
  end

  always @(posedge w_clock) begin
    exp_t e;
    cyc++;
    #1;
    if (started && w_rst_n) begin
      if (r_oe) begin
        if (exp_q.size() == 0) chk("spurious_oe", 32'(r_oe), 0);
        else begin
          e = exp_q.pop_front();
          chk("insn", r_insn, e.insn);
          chk("latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end else chk("idle_insn", r_insn, 0);
    end
  end

  task automatic do_reset(input logic [31:0] pc);
    w_rst_n = 0;
    w_re = 0;
    inval_pulse = 0;
    repeat (3) @(negedge w_clock);
    exp_q.delete();
    mv = '{default: 0};
    w_rst_n = 1;
    started = 1;
    w_pc = pc;
    w_re = 1;
    for (int i = 0; i < MEM_DELAY; i++) begin
      chk("drain_mem_re", 32'(w_mem_re), 0);
      chk("drain_oe", 32'(r_oe), 0);
      @(negedge w_clock);
    end
  endtask

  task automatic inval_idle();
    inval_pulse = 1;
    mv = '{default: 0};
    @(negedge w_clock);
    inval_pulse = 0;
  endtask

  // called at the negedge of a cycle in which the cache is idle
  task automatic fetch(input logic [31:0] pc, input bit hold, input bit inv);
    exp_t e;
    int unsigned i;
    bit hit;
    w_pc = pc;
    w_re = 1;
    inval_pulse = inv;
    i = m_idx(pc);
    hit = mv[i] && mt[i] == m_tag(pc);
    e.insn = hit ? md[i] : mem[m_word(pc)];
    e.issue = cyc;
    e.lat = hit ? 1 : MISS_LAT;
    if (inv) mv = '{default: 0};
    if (!hit) begin
      mv[i] = 1;
      mt[i] = m_tag(pc);
      md[i] = e.insn;
      if (inval_on_fill) mv = '{default: 0};
    end
    exp_q.push_back(e);
    @(negedge w_clock);
    inval_pulse = 0;
    chk(hit ? "hit_mem_re" : "miss_mem_re", 32'(w_mem_re), hit ? 0 : 1);
    if (!hit) chk("miss_addr", w_mem_addr, pc);
    if (hold) w_pc = $urandom;
    else w_re = 0;
    for (int k = 0; k < 3 * MISS_LAT && exp_q.size() != 0; k++) @(negedge w_clock);
    if (exp_q.size() != 0) begin
      chk("timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
    @(negedge w_clock);
    w_re = 0;
  endtask

  initial begin
    logic [31:0] pc;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[0] = 32'h0010_0093;
    mem[2] = 32'hDEAD_0002;
    mem[3] = 32'h0030_0193;
    mem[16] = 32'h0020_8113;
    @(negedge w_clock);
    do_reset(32'h0);
    fetch(32'h0, 0, 0);
    fetch(32'h0, 0, 0);
    fetch(32'h40, 0, 0);
    fetch(32'h0, 0, 0);
    fetch(32'h4, 0, 0);
    inval_idle();
    fetch(32'h4, 0, 0);
    inval_on_fill = 1;
    fetch(32'h44, 0, 0);
    inval_on_fill = 0;
    fetch(32'h44, 0, 0);
    fetch(32'h44, 0, 1);
    fetch(32'h44, 0, 0);
    w_pc = 32'h8;
    w_re = 1;
    repeat (4) @(negedge w_clock);
    chk("mid_miss_re", 32'(w_mem_re), 1);
    do_reset(32'hC);
    fetch(32'hC, 0, 0);
`ifdef ICACHE_STATS_EN
    chk("stat_hits", dut.r_hits, 0);
    chk("stat_misses", dut.r_misses, 1);
`endif
    for (int n = 0; n < 300; n++) begin
      pc = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) pc = pc | ($urandom & 32'hFFFF_E000);
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 63)] = $urandom;
      inval_on_fill = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 19) == 0) inval_idle();
      fetch(pc, 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    inval_on_fill = 0;
    repeat (3) @(negedge w_clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
